// File: rtl/frame_streamer_pkg.sv
// Shared definitions for the frame read-back path.
//   - image geometry defaults (also used by the test-pattern writer)
//   - SRAM/pixel widths and 24-bit RGB colour constants
//   - frame_streamer FSM state encoding
//   - frame_pixels(): W*H evaluated in 32 bits
package frame_streamer_pkg;

  // Geometry defaults shared with the test-pattern writer.
  localparam int unsigned DefImgWidth  = 32;
  localparam int unsigned DefImgHeight = 32;

  localparam int unsigned AddrW  = 18;
  localparam int unsigned WordW  = 32;
  localparam int unsigned PixelW = 24;
  localparam int unsigned CountW = 16;

  // RGB888, red in [23:16].
  localparam logic [PixelW-1:0] ColBlack   = 24'h000000;
  localparam logic [PixelW-1:0] ColWhite   = 24'hFFFFFF;
  localparam logic [PixelW-1:0] ColRed     = 24'hFF0000;
  localparam logic [PixelW-1:0] ColGreen   = 24'h00FF00;
  localparam logic [PixelW-1:0] ColBlue    = 24'h0000FF;
  localparam logic [PixelW-1:0] ColYellow  = 24'hFFFF00;
  localparam logic [PixelW-1:0] ColCyan    = 24'h00FFFF;
  localparam logic [PixelW-1:0] ColMagenta = 24'hFF00FF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic logic [31:0] frame_pixels(input int unsigned width,
                                               input int unsigned height);
    return 32'(width * height);
  endfunction

endpackage

// File: rtl/frame_streamer_fifo.sv
// stream_fifo: synchronous first-word-fall-through FIFO.
//   clk_i / rst_ni : clock, asynchronous active-low reset
//   push_i, wdata_i: write strobe and data
//   pop_i          : consume the head word (ignored when empty)
//   rdata_o        : head word, valid whenever empty_o is low
//   full_o, empty_o, count_o : occupancy status
// Depth must be a power of two so the pointers wrap naturally.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module stream_fifo #(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [Width-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifndef SYNTHESIS
  // The upstream credit scheme must make this impossible.
  push_on_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(push_i && full_o && !pop_i))
    else $error("stream_fifo: push into a full FIFO");
`endif

endmodule

// File: rtl/frame_streamer.sv
// frame_streamer: reads a stored frame back from the 32-bit pixel SRAM and
// emits it as a raster-ordered 24-bit valid/ready pixel stream.
//   clk, reset (async, active low)
//   enable            : level; high in idle starts a frame, low in done returns to idle
//   starting_address  : frame base, pixel k lives at base+1+k (mod 2^18)
//   addr, rden        : SRAM read port, one word per rden cycle
//   data_read         : SRAM data, READ_LATENCY cycles after rden; [23:0] is the pixel
//   pixel_data/valid/ready : output stream
//   sof, eol, eof     : frame/line markers qualifying the head pixel
//   done              : frame fully delivered, held until enable drops
// Reads are credit limited: a read is issued only while words in flight plus
// words buffered stay within FIFO_DEPTH, so backpressure can never overflow
// the FIFO and no pixel is dropped or duplicated.
module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH    = DefImgWidth,
  parameter int unsigned IMG_HEIGHT   = DefImgHeight,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [AddrW-1:0]  starting_address,
  input  logic [WordW-1:0]  data_read,
  output logic [AddrW-1:0]  addr,
  output logic              rden,
  output logic [PixelW-1:0] pixel_data,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              done
);

  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CreditW  = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

  localparam logic [31:0]       TotalPixels = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
  localparam logic [CountW-1:0] LastCol     = CountW'(IMG_WIDTH - 1);
  localparam logic [CountW-1:0] LastRow     = CountW'(IMG_HEIGHT - 1);

  state_e                  state_q;
  logic [AddrW-1:0]        base_q;
  logic [AddrW-1:0]        addr_q;
  logic                    rden_q;
  logic                    done_q;
  logic [CountW-1:0]       rd_count_q;
  logic [CountW-1:0]       out_count_q;
  logic [CountW-1:0]       hcount_q;
  logic [CountW-1:0]       vcount_q;
  logic [READ_LATENCY-1:0] rd_pipe_q;

  logic                    push, pop;
  logic                    start;
  logic                    last_accept;
  logic                    can_issue;
  logic [CreditW-1:0]      inflight_next;
  logic [CreditW-1:0]      credit_used;
  logic [PixelW-1:0]       fifo_head;
  logic                    fifo_empty;
  logic                    unused_fifo_full;
  logic [FifoCntW-1:0]     fifo_count;
  logic                    unused_data_msb;

  assign unused_data_msb = ^data_read[WordW-1:PixelW];

  // -------------------------------------------------------------------------
  // Read-data capture: the delay line follows rden so the word is written
  // exactly READ_LATENCY cycles after its strobe.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pipe_q <= '0;
    end else begin
      rd_pipe_q[0] <= rden_q;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
    end
  end

  assign push = rd_pipe_q[READ_LATENCY-1];

  stream_fifo #(
    .Width (PixelW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .wdata_i (data_read[PixelW-1:0]),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (unused_fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pixel_valid = !fifo_empty;
  assign pop         = pixel_valid && pixel_ready;
  assign pixel_data  = pixel_valid ? fifo_head : ColBlack;

  // -------------------------------------------------------------------------
  // Credit: occupancy as it will stand after this edge (reads still in flight
  // plus FIFO contents). A new read is issued only if it fits.
  // -------------------------------------------------------------------------
  always_comb begin
    inflight_next = CreditW'(rden_q);
    for (int i = 0; i < int'(READ_LATENCY) - 1; i++) begin
      inflight_next = inflight_next + CreditW'(rd_pipe_q[i]);
    end
    credit_used = inflight_next + CreditW'(fifo_count) + CreditW'(push) - CreditW'(pop);
  end

  assign can_issue   = (credit_used < CreditW'(FIFO_DEPTH));
  assign start       = (state_q == StIdle) && enable;
  assign last_accept = pop && ((32'(out_count_q) + 32'd1) == TotalPixels);

  // -------------------------------------------------------------------------
  // Control FSM. The first read goes out on the idle->read edge itself, which
  // puts the first pixel on the output READ_LATENCY+1 cycles after start.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      base_q     <= '0;
      addr_q     <= '0;
      rden_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_count_q <= '0;
    end else begin
      rden_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (enable) begin
            base_q     <= starting_address;
            addr_q     <= starting_address + AddrW'(1);
            rden_q     <= 1'b1;
            rd_count_q <= CountW'(1);
            state_q    <= (TotalPixels == 32'd1) ? StDrain : StRead;
          end
        end
        StRead: begin
          if (can_issue) begin
            addr_q     <= base_q + AddrW'(1) + AddrW'(rd_count_q);
            rden_q     <= 1'b1;
            rd_count_q <= rd_count_q + CountW'(1);
            if ((32'(rd_count_q) + 32'd1) == TotalPixels) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (last_accept) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (!enable) begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output position counters, advanced only on accept.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_count_q <= '0;
      hcount_q    <= '0;
      vcount_q    <= '0;
    end else if (start) begin
      out_count_q <= '0;
      hcount_q    <= '0;
      vcount_q    <= '0;
    end else if (pop) begin
      out_count_q <= out_count_q + CountW'(1);
      if (hcount_q == LastCol) begin
        hcount_q <= '0;
        vcount_q <= (vcount_q == LastRow) ? '0 : vcount_q + CountW'(1);
      end else begin
        hcount_q <= hcount_q + CountW'(1);
      end
    end
  end

  // Markers describe the head pixel, so they hold with it under backpressure.
  assign sof = pixel_valid && (hcount_q == '0) && (vcount_q == '0);
  assign eol = pixel_valid && (hcount_q == LastCol);
  assign eof = eol && (vcount_q == LastRow);

  assign addr = addr_q;
  assign rden = rden_q;
  assign done = done_q;

endmodule

// File: tb/tb_frame_streamer.sv
module tb_frame_streamer;

  localparam int unsigned W = 32;
  localparam int unsigned H = 32;
  localparam int unsigned L = 2;   // the SRAM model below has a fixed 2-cycle latency
  localparam int unsigned D = 4;
  localparam int unsigned N = W * H;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [17:0] starting_address;
  logic [31:0] data_read = '0;
  logic [17:0] addr;
  logic        rden;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        sof, eol, eof, done;

  always #5 clk = ~clk;

  frame_streamer #(
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .READ_LATENCY (L),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .starting_address (starting_address),
    .data_read        (data_read),
    .addr             (addr),
    .rden             (rden),
    .pixel_data       (pixel_data),
    .pixel_valid      (pixel_valid),
    .pixel_ready      (pixel_ready),
    .sof              (sof),
    .eol              (eol),
    .eof              (eof),
    .done             (done)
  );

  typedef struct packed {
    logic [23:0] px;
    logic        sof;
    logic        eol;
    logic        eof;
  } beat_t;

  beat_t       exp_px_q[$];
  logic [17:0] exp_addr_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_reads  = 0;
  int n_acc    = 0;
  int cyc      = 0;
  int first_acc = 0;
  int last_acc  = 0;
  int ready_mode = 0;   // 0: always ready, 1: random 50%, 2: stalled

  logic [17:0] mem_off = '0;
  logic [23:0] salt    = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: got 0x%0h, required nothing", name, act);
  endtask

  // SRAM contents: word at address a holds (a - mem_off) ^ salt in [23:0].
  function automatic logic [23:0] sram_word(input logic [17:0] a);
    logic [17:0] d;
    d = a - mem_off;
    return {6'b0, d} ^ salt;
  endfunction

  // SRAM model, 2-cycle read latency; junk on the bus when no read is due.
  logic        req_v = 1'b0;
  logic [17:0] req_a = '0;
  always @(posedge clk) begin
    data_read <= req_v ? {8'($urandom), sram_word(req_a)} : $urandom;
    req_v     <= rden;
    req_a     <= addr;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    pixel_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       pixel_ready = 1'b1;
        1:       pixel_ready = 1'($urandom_range(0, 1));
        default: pixel_ready = 1'b0;
      endcase
    end
  end

  // Monitor: reads against the address scoreboard, accepted pixels against
  // the pixel scoreboard, plus hold stability and done timing.
  logic  hold_v   = 1'b0;
  beat_t hold_beat;
  logic  done_due = 1'b0;
  always @(negedge clk) begin
    beat_t act, req;
    if (!reset) begin
      hold_v   = 1'b0;
      done_due = 1'b0;
    end else begin
      if (done_due) begin
        check("done_after_last", done, 1);
        done_due = 1'b0;
      end
      if (rden) begin
        n_reads++;
        if (exp_addr_q.size() == 0) fail_now("read_extra", addr);
        else check("read_addr", addr, exp_addr_q.pop_front());
      end
      act = {pixel_data, sof, eol, eof};
      if (hold_v) check("hold_stable", {pixel_valid, act}, {1'b1, hold_beat});
      if (pixel_valid && pixel_ready) begin
        if (n_acc == 0) first_acc = cyc;
        n_acc++;
        if (exp_px_q.size() == 0) begin
          fail_now("pixel_extra", act);
        end else begin
          req = exp_px_q.pop_front();
          check("pixel", act, req);
          if (req.eof) begin
            check("done_early", done, 0);
            done_due = 1'b1;
            last_acc = cyc;
          end
        end
      end
      hold_v    = pixel_valid && !pixel_ready;
      hold_beat = act;
    end
  end

  // Reference model: pixel k is read from base+1+k (mod 2^18) in raster order.
  task automatic load_frame(input logic [17:0] base, input logic [23:0] s);
    beat_t       b;
    logic [17:0] a;
    exp_px_q.delete();
    exp_addr_q.delete();
    mem_off = base;
    salt = s;
    starting_address = base;
    n_reads = 0;
    n_acc = 0;
    for (int k = 0; k < int'(N); k++) begin
      a = base + 18'(k + 1);
      exp_addr_q.push_back(a);
      b.px  = sram_word(a);
      b.sof = (k == 0);
      b.eol = ((k % W) == W - 1);
      b.eof = (k == int'(N) - 1);
      exp_px_q.push_back(b);
    end
  endtask

  task automatic finish_frame(input string name);
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    check({name, "_done"}, done, 1);
    check({name, "_pixels_left"}, exp_px_q.size(), 0);
    check({name, "_reads_left"}, exp_addr_q.size(), 0);
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #1;
      if (n_acc >= n) break;
    end
    check("wait_accepts", n_acc >= n, 1);
  endtask

  task automatic idle_gap();
    enable = 1'b0;
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat, r0;
    logic [17:0] base;
    logic [23:0] s;

    reset = 1'b0;
    enable = 1'b0;
    starting_address = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {addr, rden, pixel_data, pixel_valid, sof, eol, eof, done}, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic frame, always ready: values 1..0x400, first valid after L+1 cycles.
    load_frame(18'h00100, 24'h0);
    enable = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (pixel_valid) begin
        lat = i;
        break;
      end
    end
    check("first_valid_latency", lat, L + 1);
    finish_frame("basic");
    check("basic_throughput", last_acc - first_acc, N - 1);
    check("basic_reads", n_reads, N);
    idle_gap();

    // Random backpressure.
    load_frame(18'($urandom), 24'($urandom));
    ready_mode = 1;
    enable = 1'b1;
    finish_frame("backpressure");
    idle_gap();

    // Stall mid-line: reads stop once D words are in flight or buffered.
    load_frame(18'h01000, 24'($urandom));
    enable = 1'b1;
    wait_acc(100);
    ready_mode = 2;
    repeat (10) @(posedge clk);
    #1;
    r0 = n_reads;
    repeat (40) @(posedge clk);
    #1;
    check("stall_no_reads", n_reads - r0, 0);
    check("stall_credit", n_reads - n_acc, D);
    check("stall_valid", pixel_valid, 1);
    ready_mode = 0;
    finish_frame("stall");
    idle_gap();

    // Address wrap 0x3FFFF -> 0x00000.
    load_frame(18'h3FFF0, 24'($urandom));
    ready_mode = 1;
    enable = 1'b1;
    finish_frame("wrap");
    check("wrap_reads", n_reads, N);
    idle_gap();

    // Asynchronous reset mid-frame, then restart from pixel 0.
    base = 18'h2A000;
    s = 24'($urandom);
    load_frame(base, s);
    ready_mode = 1;
    enable = 1'b1;
    wait_acc(300);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_outputs",
          {addr, rden, pixel_data, pixel_valid, sof, eol, eof, done}, 0);
    load_frame(base, s);
    @(posedge clk);
    #1;
    reset = 1'b1;
    finish_frame("after_reset");
    idle_gap();

    // Done protocol: done holds while enable stays high, no reads; then a
    // second identical frame.
    base = 18'h00200;
    s = 24'($urandom);
    load_frame(base, s);
    ready_mode = 1;
    enable = 1'b1;
    finish_frame("done_proto_1");
    r0 = n_reads;
    repeat (30) @(posedge clk);
    #1;
    check("done_held", done, 1);
    check("done_no_reads", n_reads - r0, 0);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("done_cleared", done, 0);
    load_frame(base, s);
    enable = 1'b1;
    finish_frame("done_proto_2");
    check("done_proto_2_reads", n_reads, N);
    idle_gap();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
- Downstream consumer of the test-pattern writer: once the pattern writer asserts done, this block reads the stored frame back out of the shared 32-bit pixel SRAM.
- Emits the frame as a raster-ordered 24-bit pixel stream with valid/ready handshake and sof/eol/eof markers, for the display/UART output path.
- Hides SRAM read latency behind a small credit-controlled FIFO so backpressure never drops or duplicates a pixel.

Parameters:
IMG_WIDTH, 32, pixels per line
IMG_HEIGHT, 32, lines per frame
READ_LATENCY, 2, cycles from rden/addr to valid data_read (1..4)
FIFO_DEPTH, 4, pixel FIFO entries, power of two, >= READ_LATENCY+1

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  level; high in IDLE starts a frame
starting_address  in  18  frame base; sampled at start
data_read  in  32  SRAM read data; pixel in bits [23:0]
addr  out  18  SRAM read address
rden  out  1  SRAM read strobe, one word per high cycle
pixel_data  out  24  RGB pixel
pixel_valid  out  1  pixel_data valid
pixel_ready  in  1  consumer accepts when valid&&ready
sof  out  1  qualifies first pixel of frame
eol  out  1  qualifies last pixel of each line
eof  out  1  qualifies last pixel of frame
done  out  1  frame fully delivered; held until enable low

Behaviour:
- Reset (reset low, any time incl. mid-frame): state IDLE; addr=0, rden=0, pixel_data=0, pixel_valid=0, sof/eol/eof=0, done=0. FIFO, credit and counters cleared; in-flight reads discarded.
- Frame layout: pixel k (k=0..W*H-1) at starting_address+1+k, mod 2^18; wraps 0x3FFFF->0x00000 without error.
- States: IDLE -> READ on enable=1; latch base, clear rd_count, out_count, hcount, vcount.
- READ: rden=1 and addr=base+1+rd_count when issued = outstanding+fifo_count < FIFO_DEPTH, and rd_count < W*H.
- READ: after the last issue, go to DRAIN.
- DRAIN: no reads; go to DONE when the last pixel is accepted.
- DONE: done=1, rden=0, pixel_valid=0; go to IDLE when enable=0.
- enable dropping during READ/DRAIN has no effect; the frame completes.
- Read data capture: delay line of READ_LATENCY stages tracks rden; data_read[23:0] is pushed into the FIFO exactly READ_LATENCY cycles after its rden. Bits [31:24] are ignored.
- Credit rule guarantees the FIFO never overflows. A push on a full FIFO is a design error; simulation assertion only.
- Output: pixel_valid = FIFO non-empty; pixel_data = FIFO head. Registered/first-word-fall-through; no combinational path from pixel_ready to pixel_valid.
- Handshake: once valid rises, pixel_data and markers stay stable until accepted.
- Counters: hcount 0..W-1 and vcount 0..H-1 advance only on accept. Markers are computed from out_count at the FIFO head:
  - sof = (hcount==0 && vcount==0)
  - eol = (hcount==W-1)
  - eof = (eol && vcount==H-1)
- Simultaneous push and pop on a full FIFO is allowed; count unchanged.
- Latency with ready held high: first pixel_valid READ_LATENCY+1 cycles after leaving IDLE. Sustained throughput is 1 pixel/cycle.
- Counter widths: 16-bit counters; products W*H computed in 32 bits.

Decomposition:
- Shared package: colour constants and image geometry defaults (IMG_WIDTH/IMG_HEIGHT, also used by the pattern writer), plus state encodings IDLE=0, READ=1, DRAIN=2, DONE=3.
- One sub-module, stream_fifo: synchronous FWFT FIFO, parameters width 24 and depth FIFO_DEPTH, with push/pop/full/empty/count outputs and async active-low reset.

Test Plan:
- Basic frame: base=0x00100, SRAM model preloaded with word k = k, pixel_ready=1. Expect:
  - 1024 pixels with values 0x000001..0x000400 in order.
  - sof on the first pixel only; eol on every 32nd pixel; eof on pixel 1024.
  - done one cycle after the last accept.
- Backpressure: pixel_ready random at 50%. Expect the identical pixel sequence with no drops or duplicates, and data held stable while valid&&!ready.
- Stall: pixel_ready=0 for 50 cycles mid-line. Expect rden to stop after exactly FIFO_DEPTH outstanding+buffered words (4), then resume with the correct addr.
- Wrap: base=0x3FFF0. Expect addresses 0x3FFF1..0x3FFFF, then 0x00000 onward; total 1024 reads.
- Reset mid-frame: drop reset after 300 pixels. Expect:
  - All outputs 0 within the same cycle (async).
  - After release with enable=1, the frame restarts from pixel 0 with sof=1.
- Done protocol: hold enable=1 after done. Expect done to stay 1 with no new reads; enable low -> IDLE; enable high starts a second identical frame.
